// File: rtl/decoupled_demux_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared defaults and width helper for the demux queue slice.
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

    localparam int unsigned DEF_N     = 4;
    localparam int unsigned DEF_W     = 32;
    localparam int unsigned DEF_DEPTH = 2;

    // clog2 that never returns less than one bit, for selects and pointers
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoupled_demux_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : decoupled_demux_queue_if
// Purpose  : Producer stream plus N consumer ports of the demux queue.
// Revision : 1.0 - initial release
// ============================================================================
interface decoupled_demux_queue_if
    import demux_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);
    localparam int c_SEL_W = clog2_min1(N);

    logic               io_in_valid;
    logic               io_in_ready;
    logic [c_SEL_W-1:0] io_in_bits_sel;
    logic [W-1:0]       io_in_bits_data;
    logic [N-1:0]       io_out_valid;
    logic [N-1:0]       io_out_ready;
    logic [N*W-1:0]     io_out_bits_data;
    logic               io_err;

    modport slave (
        input  io_in_valid, io_in_bits_sel, io_in_bits_data, io_out_ready,
        output io_in_ready, io_out_valid, io_out_bits_data, io_err
    );

    modport master (
        output io_in_valid, io_in_bits_sel, io_in_bits_data, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_bits_data, io_err
    );

endinterface
`default_nettype wire

// File: rtl/decoupled_demux_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : decoupled_fifo
// Purpose  : Small ready/valid FIFO, arbitrary depth, no flow-through/bypass.
// Revision : 1.0 - initial release
// ============================================================================
module decoupled_fifo
    import demux_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  wire logic         clock,
    input  wire logic         reset,
    input  wire logic         enq_valid,
    output logic              enq_ready,
    input  wire logic [W-1:0] enq_bits,
    output logic              deq_valid,
    input  wire logic         deq_ready,
    output logic [W-1:0]      deq_bits
);
    localparam int c_PTR_W = clog2_min1(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [W-1:0]       r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               w_enq_fire;
    logic               w_deq_fire;

    // Explicit wrap compare so non power-of-2 depths work
    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + 1'b1;
    endfunction

    assign enq_ready  = (r_count != c_FULL);
    assign deq_valid  = (r_count != '0);
    assign deq_bits   = r_mem[r_head];
    assign w_enq_fire = enq_valid && enq_ready;
    assign w_deq_fire = deq_valid && deq_ready;

    always_ff @(posedge clock) begin
        if (w_enq_fire) begin
            r_mem[r_tail] <= enq_bits;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq_fire) begin
                r_tail <= next_ptr(r_tail);
            end
            if (w_deq_fire) begin
                r_head <= next_ptr(r_head);
            end
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoupled_demux_queue.sv
`default_nettype none
// ============================================================================
// Module   : decoupled_demux_queue
// Purpose  : Steers one ready/valid stream to N per-port FIFOs by select.
// Revision : 1.0 - initial release
// ============================================================================
module decoupled_demux_queue
    import demux_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int W     = DEF_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  wire logic              clock,
    input  wire logic              reset,
    decoupled_demux_queue_if.slave bus
);
    localparam int c_SEL_W = clog2_min1(N);

    logic [N-1:0] w_enq_valid;
    logic [N-1:0] w_enq_ready;
    logic         w_in_ready;
    logic         w_in_range;
    logic         r_err;

    // Out-of-range selects are always accepted and dropped
    always_comb begin
        w_in_ready  = 1'b1;
        w_in_range  = 1'b0;
        w_enq_valid = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.io_in_bits_sel == c_SEL_W'(i)) begin
                w_in_range     = 1'b1;
                w_in_ready     = w_enq_ready[i];
                w_enq_valid[i] = bus.io_in_valid;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (bus.io_in_valid && !w_in_range) begin
            r_err <= 1'b1;
        end
    end

    assign bus.io_in_ready = w_in_ready;
    assign bus.io_err      = r_err;

    for (genvar i = 0; i < N; i++) begin : g_fifo
        decoupled_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .enq_valid (w_enq_valid[i]),
            .enq_ready (w_enq_ready[i]),
            .enq_bits  (bus.io_in_bits_data),
            .deq_valid (bus.io_out_valid[i]),
            .deq_ready (bus.io_out_ready[i]),
            .deq_bits  (bus.io_out_bits_data[i*W +: W])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_decoupled_demux_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoupled_demux_queue
// Purpose  : Directed scoreboard bench for the N=4 and N=3 demux queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoupled_demux_queue;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] sb [4][$];

    always #5 clk = ~clk;

    decoupled_demux_queue_if #(.N(4), .W(32)) bus4 ();
    decoupled_demux_queue_if #(.N(3), .W(32)) bus3 ();

    decoupled_demux_queue #(.N(4), .W(32), .DEPTH(2)) u_dut4 (
        .clock (clk),
        .reset (rst),
        .bus   (bus4.slave)
    );

    decoupled_demux_queue #(.N(3), .W(32), .DEPTH(2)) u_dut3 (
        .clock (clk),
        .reset (rst),
        .bus   (bus3.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat to the N=4 instance; scoreboard records it only if it fires
    task automatic send4(input int sel, input logic [31:0] data, output logic rdy);
        bus4.io_in_valid     = 1'b1;
        bus4.io_in_bits_sel  = 2'(sel);
        bus4.io_in_bits_data = data;
        #1;
        rdy = bus4.io_in_ready;
        tick();
        if (rdy) sb[sel].push_back(data);
        bus4.io_in_valid = 1'b0;
    endtask

    task automatic deq4(input int i);
        logic [31:0] exp;
        exp = sb[i].pop_front();
        chk($sformatf("deq%0d_valid", i), 64'(bus4.io_out_valid[i]), 64'd1);
        chk($sformatf("deq%0d_data", i), 64'(bus4.io_out_bits_data[i*32 +: 32]), 64'(exp));
        bus4.io_out_ready[i] = 1'b1;
        tick();
        bus4.io_out_ready[i] = 1'b0;
    endtask

    initial begin
        logic rdy;
        logic [31:0] hd;
        bus4.io_in_valid = 1'b0; bus4.io_in_bits_sel = '0; bus4.io_in_bits_data = '0;
        bus4.io_out_ready = '0;
        bus3.io_in_valid = 1'b0; bus3.io_in_bits_sel = '0; bus3.io_in_bits_data = '0;
        bus3.io_out_ready = '0;

        // 1. reset then idle
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_valid4", 64'(bus4.io_out_valid), 64'h0);
        chk("rst_err4", 64'(bus4.io_err), 64'h0);
        chk("rst_valid3", 64'(bus3.io_out_valid), 64'h0);
        chk("rst_err3", 64'(bus3.io_err), 64'h0);
        for (int s = 0; s < 4; s++) begin
            bus4.io_in_bits_sel = 2'(s);
            #1;
            chk($sformatf("rst_ready_sel%0d", s), 64'(bus4.io_in_ready), 64'd1);
        end

        // 2. single route, no flow-through while empty
        bus4.io_in_valid = 1'b1; bus4.io_in_bits_sel = 2'd2; bus4.io_in_bits_data = 32'hA5A5_0001;
        #1;
        chk("no_flow_through", 64'(bus4.io_out_valid), 64'h0);
        send4(2, 32'hA5A5_0001, rdy);
        chk("route_ready", 64'(rdy), 64'd1);
        chk("route_valid", 64'(bus4.io_out_valid), 64'b0100);
        chk("route_data", 64'(bus4.io_out_bits_data[64 +: 32]), 64'hA5A5_0001);
        deq4(2);
        chk("route_drained", 64'(bus4.io_out_valid), 64'h0);

        // 3. fill and block, no bypass when full
        send4(1, 32'h1111_0001, rdy);
        chk("fill_rdy0", 64'(rdy), 64'd1);
        send4(1, 32'h1111_0002, rdy);
        chk("fill_rdy1", 64'(rdy), 64'd1);
        bus4.io_in_valid = 1'b1; bus4.io_in_bits_sel = 2'd1; bus4.io_in_bits_data = 32'h1111_0003;
        #1;
        chk("full_ready_sel1", 64'(bus4.io_in_ready), 64'd0);
        bus4.io_in_bits_sel = 2'd0;
        #1;
        chk("other_ready_sel0", 64'(bus4.io_in_ready), 64'd1);
        bus4.io_in_bits_sel = 2'd1;
        bus4.io_out_ready[1] = 1'b1;
        #1;
        chk("full_no_bypass", 64'(bus4.io_in_ready), 64'd0);
        hd = sb[1].pop_front();
        chk("full_head_first", 64'(bus4.io_out_bits_data[32 +: 32]), 64'(hd));
        tick();
        bus4.io_out_ready[1] = 1'b0;
        #1;
        chk("ready_returns", 64'(bus4.io_in_ready), 64'd1);
        bus4.io_in_valid = 1'b0;
        deq4(1);
        chk("fill_drained", 64'(bus4.io_out_valid), 64'h0);

        // 4. concurrent enq/deq on output 3
        send4(3, 32'h3333_0001, rdy);
        bus4.io_in_valid = 1'b1; bus4.io_in_bits_sel = 2'd3; bus4.io_in_bits_data = 32'h3333_0002;
        bus4.io_out_ready[3] = 1'b1;
        #1;
        chk("cc_ready", 64'(bus4.io_in_ready), 64'd1);
        hd = sb[3].pop_front();
        chk("cc_old_head", 64'(bus4.io_out_bits_data[96 +: 32]), 64'(hd));
        tick();
        sb[3].push_back(32'h3333_0002);
        bus4.io_in_valid = 1'b0; bus4.io_out_ready[3] = 1'b0;
        chk("cc_valid", 64'(bus4.io_out_valid), 64'b1000);
        deq4(3);
        chk("cc_count_one", 64'(bus4.io_out_valid), 64'h0);

        // pointer wrap on output 0, then all outputs dequeue together
        for (int k = 0; k < 5; k++) begin
            send4(0, 32'h0C00_0000 + 32'(k), rdy);
            deq4(0);
        end
        for (int s = 0; s < 4; s++) send4(s, 32'hAB00_0000 + 32'(s), rdy);
        chk("all_valid", 64'(bus4.io_out_valid), 64'b1111);
        for (int s = 0; s < 4; s++) begin
            hd = sb[s].pop_front();
            chk($sformatf("all_head%0d", s), 64'(bus4.io_out_bits_data[s*32 +: 32]), 64'(hd));
        end
        bus4.io_out_ready = 4'b1111;
        tick();
        bus4.io_out_ready = '0;
        chk("all_drained", 64'(bus4.io_out_valid), 64'h0);

        // 5. out-of-range select on N=3 instance
        bus3.io_in_valid = 1'b1; bus3.io_in_bits_sel = 2'd3; bus3.io_in_bits_data = 32'hDEAD_BEEF;
        #1;
        chk("oor_ready", 64'(bus3.io_in_ready), 64'd1);
        chk("oor_err_before", 64'(bus3.io_err), 64'd0);
        tick();
        bus3.io_in_valid = 1'b0;
        chk("oor_no_valid", 64'(bus3.io_out_valid), 64'h0);
        chk("oor_err_set", 64'(bus3.io_err), 64'd1);
        tick(); tick();
        chk("oor_err_sticky", 64'(bus3.io_err), 64'd1);
        chk("oor_err4_clear", 64'(bus4.io_err), 64'd0);

        // 6. reset mid-stream with a concurrent enqueue
        send4(0, 32'h0000_F000, rdy);
        send4(2, 32'h0000_F002, rdy);
        chk("pre_rst_valid", 64'(bus4.io_out_valid), 64'b0101);
        rst = 1'b1;
        bus4.io_in_valid = 1'b1; bus4.io_in_bits_sel = 2'd1; bus4.io_in_bits_data = 32'h0000_F001;
        tick();
        rst = 1'b0;
        bus4.io_in_valid = 1'b0;
        for (int s = 0; s < 4; s++) sb[s].delete();
        chk("mid_rst_valid", 64'(bus4.io_out_valid), 64'h0);
        chk("mid_rst_err3", 64'(bus3.io_err), 64'd0);
        tick();
        chk("mid_rst_beat_lost", 64'(bus4.io_out_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decoupled_demux_queue.md
Name: decoupled_demux_queue

Overview:
- Fan-out counterpart of the request arbiters: one ready/valid producer stream is steered to one of N consumer ports by a select field in the payload.
- Each output has a small FIFO, so one stalled consumer does not block traffic addressed to the others.
- Sits between a shared response/issue bus and per-unit consumers in the core.

Parameters:
- N, 4, number of output ports (N >= 2)
- W, 32, payload data width in bits
- DEPTH, 2, entries per output FIFO (DEPTH >= 1, need not be a power of 2)
- SEL_W, max(1, clog2(N)), width of the select field (derived, not user-set)

Ports:
- clock  input  1  sole clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- io_in_valid  input  1  producer has a beat
- io_in_ready  output  1  demux can accept the beat this cycle
- io_in_bits_sel  input  SEL_W  destination port index
- io_in_bits_data  input  W  payload
- io_out_valid  output  N  bit i: output i head entry valid
- io_out_ready  input  N  bit i: consumer i accepts head
- io_out_bits_data  output  N*W  slice [i*W +: W] is head payload of output i
- io_err  output  1  sticky flag: a beat with sel >= N was accepted

Behaviour:
- Reset:
  - All FIFOs empty: pointers = 0, counts = 0.
  - io_out_valid = 0, io_err = 0.
  - Storage is not reset; io_out_bits_data is don't-care while the matching valid = 0.
- Handshake:
  - A fire is valid && ready in the same cycle.
  - Ready is combinational from sel and the FIFO full state.
  - Valid never depends on ready.
- io_in_ready:
  - sel < N: ready = !full[sel].
  - sel >= N: ready = 1.
  - Ready may toggle with sel while io_in_valid = 0.
- Enqueue (in fire with sel < N):
  - Write data at tail[sel].
  - Advance tail[sel], wrapping from DEPTH-1 to 0.
  - Increment count[sel].
- Out-of-range (in fire with sel >= N):
  - Beat is dropped.
  - io_err is set on the next edge and stays high until reset.
- Dequeue (fire on output i):
  - Advance head[i] with wrap.
  - Decrement count[i].
- Output signals:
  - io_out_valid[i] = (count[i] != 0).
  - Data is the entry at head[i].
- Latency:
  - An enqueued beat is visible on its output the cycle after the in fire.
  - No combinational flow-through when a FIFO is empty.
- Simultaneous enq and deq on the same FIFO:
  - Allowed when not full: count unchanged, both pointers advance.
  - When full, in_ready = 0 even if that output dequeues this cycle (no pipe bypass).
- Concurrency:
  - All N outputs may dequeue in the same cycle.
  - At most one enqueue per cycle, into exactly one FIFO.
- Ordering: FIFO order per output; no ordering guarantee across outputs.
- Reset mid-operation: reset has priority over enq/deq in that cycle; all buffered beats are discarded.
- Arithmetic widths:
  - count is clog2(DEPTH+1) bits.
  - Pointers are max(1, clog2(DEPTH)) bits with explicit wrap compare (no power-of-2 reliance).

Decomposition:
- Shared package (demux_pkg):
  - sel/data width helper function (clog2 with min 1).
  - Default parameter constants.
- Sub-module: decoupled_fifo
  - Parameters W, DEPTH.
  - Ports: clock, reset, enq_valid/enq_ready/enq_bits, deq_valid/deq_ready/deq_bits.
  - Instantiated N times.
- Top level holds the select decode, ready mux and io_err register.

Test Plan:
1. Reset then idle: hold reset 2 cycles, release → io_out_valid = 0000, io_err = 0, io_in_ready = 1 for every sel 0..3.
2. Single route:
   - Stimulus: send data 0xA5A5_0001 with sel = 2; io_out_ready = 0.
   - Required: io_out_valid = 0100 on the next cycle, slice 2 = 0xA5A5_0001.
3. Fill and block:
   - Stimulus: send 2 beats to sel = 1 with io_out_ready = 0.
   - Required: third beat sees io_in_ready = 0 for sel = 1 and io_in_ready = 1 for sel = 0.
   - Stimulus: raise io_out_ready[1] for 1 cycle.
   - Required: io_in_ready for sel = 1 returns 1 the following cycle; the first beat drains first.
4. Concurrent enq/deq:
   - Stimulus: output 3 holds 1 entry; enqueue to sel = 3 while io_out_ready[3] = 1.
   - Required: count stays 1, head data becomes the new beat next cycle.
5. Out-of-range:
   - Stimulus: N = 3 instance, send sel = 3 with valid.
   - Required: io_in_ready = 1, no output valid rises, io_err = 1 from the next cycle and persists until reset.
6. Reset mid-stream:
   - Stimulus: fill outputs 0 and 2 with 1 beat each, assert reset 1 cycle concurrent with an enqueue.
   - Required: all valids 0 after reset, the enqueued beat is lost, io_err cleared.
